adder_acc_seq: RTL and testbench
================================

Name: adder_acc_seq

Overview:
Downstream consumer of the sequential adder stage. Takes the adder's (DATA_WIDTH+1)-bit sum stream plus its valid, and accumulates NUM_TERMS valid sums into one reduced result. Emits that result with a one-cycle valid pulse. Forms the tail of the reduction path, e.g. tree partial sums into a final dot-product/row sum.

Parameters:
DATA_WIDTH, 4, operand width of the upstream adder; input is DATA_WIDTH+1 bits.
NUM_TERMS, 4, number of valid inputs summed per output; must be >= 1.
CNT_WIDTH, max(1,$clog2(NUM_TERMS)), derived: term counter width and result growth bits.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_en  input  1  stage enable; low freezes all state
i_clear  input  1  synchronous flush of the partial window
i_valid  input  1  input sum valid (driven by adder o_valid)
i_data_bus  input  DATA_WIDTH+1  input sum, unsigned (adder o_data_bus)
o_valid  output  1  result valid, one-cycle pulse per completed window
o_data_bus  output  DATA_WIDTH+1+CNT_WIDTH  accumulated result, unsigned
o_busy  output  1  high while a partial window is held (count != 0)

Behaviour:
- Reset (async, rst_n=0): acc=0, count=0, state=IDLE, o_valid=0, o_data_bus=0, o_busy=0. Reset mid-window discards the partial sum; no output is produced for it.
- Arithmetic: unsigned. Input is zero-extended to OUT width = DATA_WIDTH+1+CNT_WIDTH. No overflow is possible: NUM_TERMS*(2^(DATA_WIDTH+1)-1) fits. No saturation logic.
- Accept condition: i_en & i_valid & ~i_clear.
- FSM states:
  - IDLE (count==0): on accept with NUM_TERMS>1, acc<=in, count<=1, go ACCUM.
  - ACCUM: on accept, if count==NUM_TERMS-1 (last term): o_data_bus<=acc+in, o_valid<=1, acc<=0, count<=0, go IDLE. Otherwise acc<=acc+in, count<=count+1.
- Latency: o_valid asserts exactly 1 cycle after the clock edge that samples the last term.
- Back-to-back windows: no bubble. The term after the last term of window k is accepted as term 0 of window k+1 on the next cycle.
- NUM_TERMS==1: every accept produces o_data_bus<=zero-extended in, o_valid<=1 next cycle; the FSM stays IDLE.
- Gaps: i_valid low leaves acc/count unchanged; windows may span any number of idle cycles.
- o_valid is high only the cycle after a completing accept. It is 0 in every other cycle, including all cycles with i_en=0.
- o_data_bus holds the last result until the next completion. It is never driven X.
- i_en=0: no accept; acc, count, state and o_data_bus are held; o_valid<=0.
- i_clear=1 (sampled only when i_en=1): acc<=0, count<=0, state<=IDLE, o_valid<=0. The same-cycle input is dropped (clear has priority over valid). If i_en=0, i_clear is ignored.
- o_busy = (state==ACCUM), registered-state derived, no combinational path from inputs.
- No combinational input-to-output paths; all outputs are registered or decoded from registered state.

Decomposition:
- Shared package adder_pkg: state enum (IDLE, ACCUM), width function acc_width(DATA_WIDTH, NUM_TERMS). The adder and this block both import it.
- One sub-module: acc_term_counter. Holds the CNT_WIDTH counter with inc/clear/en inputs and a last-term flag output (count==NUM_TERMS-1). Instantiated once.
- Datapath adder and output register stay in adder_acc_seq.

Test Plan (DATA_WIDTH=4, NUM_TERMS=4, output 7 bits, 10 ns clock):
1. Reset low 20 ns, then inputs 1,2,3,4 on consecutive valid cycles -> o_valid single pulse 1 cycle after "4" sampled, o_data_bus=7'd10, o_busy high across terms 2-4 then low.
2. Four inputs of 5'd31 back-to-back, followed immediately by 1,1,1,1 -> first pulse o_data_bus=7'd124 (no overflow), second pulse 4 cycles later o_data_bus=7'd4, no idle cycle between windows.
3. Inputs 2,_,3,_,_,4,5 with i_valid low in the gaps -> one pulse after "5", o_data_bus=7'd14.
4. i_en=0 for 3 cycles after 2 terms (7,8) with i_valid=1 and data 9 -> nothing accepted, o_valid=0. Then i_en=1, terms 1,1 -> o_data_bus=7'd17.
5. Terms 6,6, then i_clear=1 with i_valid=1 and data 9 -> partial flushed and 9 dropped, o_busy=0. Then 1,2,3,4 -> o_data_bus=7'd10.
6. Terms 10,10,10, then rst_n=0 asynchronously mid-cycle -> o_valid, o_data_bus, o_busy go 0 immediately. After release, 3,3,3,3 -> o_data_bus=7'd12.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and width helper for the adder reduction path
package adder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   // Result width: adder sum (dw+1) plus the growth bits of num_terms additions.
   function automatic int acc_width(input int dw, input int nt);
      return dw + 1 + ((nt > 1) ? $clog2(nt) : 1);
   endfunction

endpackage

// File: rtl/acc_term_counter.sv
// rtl/acc_term_counter.sv - term counter for the accumulation window with last-term flag
module acc_term_counter #(
   parameter int NUM_TERMS = 4,
   parameter int CNT_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 last
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS - 1);

   assign last = (count == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         if (clear) begin
            count <= '0;
         end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_acc_seq.sv
// rtl/adder_acc_seq.sv - accumulates NUM_TERMS valid adder sums into one reduced result
module adder_acc_seq
   import adder_pkg::*;
#(
   parameter  int DATA_WIDTH = 4,
   parameter  int NUM_TERMS  = 4,
   localparam int CNT_WIDTH  = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1,
   localparam int OUT_WIDTH  = acc_width(DATA_WIDTH, NUM_TERMS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic                  i_clear,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH:0]   i_data_bus,
   output logic                  o_valid,
   output logic [OUT_WIDTH-1:0]  o_data_bus,
   output logic                  o_busy
);

   acc_state_e             state;
   acc_state_e             next_state;
   logic [OUT_WIDTH-1:0]   acc;
   logic [OUT_WIDTH-1:0]   in_ext;
   logic [OUT_WIDTH-1:0]   sum;
   logic [CNT_WIDTH-1:0]   count;
   logic                   term_last;
   logic                   accept;

   assign accept = i_en & i_valid & ~i_clear;
   assign in_ext = OUT_WIDTH'(i_data_bus);
   assign o_busy = (state == ACCUM);

   acc_term_counter #(
      .NUM_TERMS (NUM_TERMS),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_term_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (i_en),
      .clear (i_clear),
      .inc   (accept),
      .count (count),
      .last  (term_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // With NUM_TERMS==1 term_last is always set, so the FSM never leaves IDLE.
   always_comb begin
      next_state = state;
      sum        = (state == IDLE) ? in_ext : acc + in_ext;
      if (i_en) begin
         if (i_clear) begin
            next_state = IDLE;
         end else if (i_valid) begin
            next_state = term_last ? IDLE : ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         o_valid    <= 1'b0;
         o_data_bus <= '0;
      end else if (!i_en) begin
         o_valid <= 1'b0;
      end else if (i_clear) begin
         acc     <= '0;
         o_valid <= 1'b0;
      end else if (accept) begin
         if (term_last) begin
            o_data_bus <= sum;
            o_valid    <= 1'b1;
            acc        <= '0;
         end else begin
            acc     <= sum;
            o_valid <= 1'b0;
         end
      end else begin
         o_valid <= 1'b0;
      end
   end

   // Guard the unused-bit lint on count; the counter value is only consumed via term_last.
   logic unused_count;
   assign unused_count = ^count;

endmodule

// File: tb/tb_adder_acc_seq.sv
// tb/tb_adder_acc_seq.sv - directed self-checking bench for adder_acc_seq
module tb_adder_acc_seq;

   logic       clk;
   logic       rst_n;
   logic       i_en;
   logic       i_clear;
   logic       i_valid;
   logic [4:0] i_data_bus;
   logic       o_valid;
   logic [6:0] o_data_bus;
   logic       o_busy;

   int n_vec;
   int n_err;

   adder_acc_seq #(
      .DATA_WIDTH (4),
      .NUM_TERMS  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (i_en),
      .i_clear    (i_clear),
      .i_valid    (i_valid),
      .i_data_bus (i_data_bus),
      .o_valid    (o_valid),
      .o_data_bus (o_data_bus),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [6:0] d, input logic b);
      check_vec({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
      check_vec({tag, ".data"},  {25'd0, o_data_bus}, {25'd0, d});
      check_vec({tag, ".busy"},  {31'd0, o_busy}, {31'd0, b});
   endtask

   // Drive one cycle of inputs, then sample 1 ns after the rising edge.
   task automatic step(input logic en, input logic clr, input logic v, input logic [4:0] d);
      i_en       = en;
      i_clear    = clr;
      i_valid    = v;
      i_data_bus = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 5'd0);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      i_en       = 1'b1;
      i_clear    = 1'b0;
      i_valid    = 1'b0;
      i_data_bus = '0;

      // 1: reset state, then 1+2+3+4
      #4;
      expect_out("reset", 1'b0, 7'd0, 1'b0);
      #16 rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b1, 5'd1);
      expect_out("t1_term1", 1'b0, 7'd0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 5'd2);
      step(1'b1, 1'b0, 1'b1, 5'd3);
      expect_out("t1_term3", 1'b0, 7'd0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 5'd4);
      expect_out("t1_done", 1'b1, 7'd10, 1'b0);
      idle();
      expect_out("t1_pulse_end", 1'b0, 7'd10, 1'b0);

      // 2: max inputs back-to-back, then 1,1,1,1 with no bubble
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 5'd31);
      expect_out("t2_max", 1'b1, 7'd124, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5'd1);
      expect_out("t2_next_term0", 1'b0, 7'd124, 1'b1);
      step(1'b1, 1'b0, 1'b1, 5'd1);
      step(1'b1, 1'b0, 1'b1, 5'd1);
      step(1'b1, 1'b0, 1'b1, 5'd1);
      expect_out("t2_ones", 1'b1, 7'd4, 1'b0);

      // 3: gaps inside a window
      step(1'b1, 1'b0, 1'b1, 5'd2);
      step(1'b1, 1'b0, 1'b0, 5'd20);
      step(1'b1, 1'b0, 1'b1, 5'd3);
      step(1'b1, 1'b0, 1'b0, 5'd20);
      step(1'b1, 1'b0, 1'b0, 5'd20);
      step(1'b1, 1'b0, 1'b1, 5'd4);
      expect_out("t3_before_last", 1'b0, 7'd4, 1'b1);
      step(1'b1, 1'b0, 1'b1, 5'd5);
      expect_out("t3_done", 1'b1, 7'd14, 1'b0);

      // 4: enable low freezes everything
      step(1'b1, 1'b0, 1'b1, 5'd7);
      step(1'b1, 1'b0, 1'b1, 5'd8);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 5'd9);
         expect_out("t4_frozen", 1'b0, 7'd14, 1'b1);
      end
      step(1'b1, 1'b0, 1'b1, 5'd1);
      step(1'b1, 1'b0, 1'b1, 5'd1);
      expect_out("t4_done", 1'b1, 7'd17, 1'b0);

      // 5: clear flushes partial and drops the same-cycle input
      step(1'b1, 1'b0, 1'b1, 5'd6);
      step(1'b1, 1'b0, 1'b1, 5'd6);
      step(1'b1, 1'b1, 1'b1, 5'd9);
      expect_out("t5_cleared", 1'b0, 7'd17, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5'd1);
      step(1'b1, 1'b0, 1'b1, 5'd2);
      step(1'b1, 1'b0, 1'b1, 5'd3);
      step(1'b1, 1'b0, 1'b1, 5'd4);
      expect_out("t5_done", 1'b1, 7'd10, 1'b0);

      // 6: asynchronous reset mid-window
      step(1'b1, 1'b0, 1'b1, 5'd10);
      step(1'b1, 1'b0, 1'b1, 5'd10);
      step(1'b1, 1'b0, 1'b1, 5'd10);
      i_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      expect_out("t6_async_rst", 1'b0, 7'd0, 1'b0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 5'd3);
      expect_out("t6_partial", 1'b0, 7'd0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 5'd3);
      expect_out("t6_done", 1'b1, 7'd12, 1'b0);
      idle();
      expect_out("t6_pulse_end", 1'b0, 7'd12, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
